// File: rtl/uart_rx_fifo.sv
// UART receiver (3-sample vote, parity/framing/break) feeding a first-word-fall-through FIFO.
// A word appears on out_data one clk after frame completion. When the FIFO is full, a completed frame is dropped and overflow pulses.

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_dat,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_dat,
  output logic                   o_vld,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_pop;
  logic             w_push;

  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_vld   = (o_count != '0);
  assign o_full  = (o_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop && o_vld;
  // full is judged before the same-clk pop, so push+pop at full both land
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_dat   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
  end
endmodule

module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          out_data,
  output logic                          out_perr,
  output logic                          out_ferr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          brk
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int M  = CLKS_PER_BIT / 2;
  localparam logic [BW-1:0] C_SMP0     = BW'(M - 1);
  localparam logic [BW-1:0] C_SMP1     = BW'(M);
  localparam logic [BW-1:0] C_SMP2     = BW'(M + 1);
  localparam logic [BW-1:0] C_BIT_END  = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] C_LAST_IDX = IW'(DATA_BITS - 1);
  localparam logic          C_LAST_STP = 1'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_PARITY  = 3'd3;
  localparam logic [2:0] S_STOP    = 3'd4;
  localparam logic [2:0] S_BRKWAIT = 3'd5;

  logic                 r_rx_meta;
  logic                 r_rxs;
  logic [1:0]           r_settle;
  logic                 r_armed;
  logic [2:0]           r_state;
  logic [BW-1:0]        r_bcnt;
  logic [IW-1:0]        r_idx;
  logic                 r_sidx;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_pbit;
  logic                 r_ferr;
  logic                 r_s0;
  logic                 r_s1;
  logic                 r_overflow;
  logic                 r_brk;

  logic                 w_vote;
  logic                 w_smp_end;
  logic                 w_bit_end;
  logic                 w_ferr_fin;
  logic                 w_par_exp;
  logic                 w_perr;
  logic                 w_break;
  logic                 w_done;
  logic                 w_push;
  logic                 w_full;
  logic [DATA_BITS+1:0] w_head;

  // The settle shift keeps the reset value of the synchroniser from arming the receiver
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
      r_settle  <= '0;
      r_armed   <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rxs     <= r_rx_meta;
      r_settle  <= {r_settle[0], 1'b1};
      if (r_settle[1] && r_rxs) r_armed <= 1'b1;
    end
  end

  assign w_vote     = (r_s0 & r_s1) | (r_s0 & r_rxs) | (r_s1 & r_rxs);
  assign w_smp_end  = (r_bcnt == C_SMP2);
  assign w_bit_end  = (r_bcnt == C_BIT_END);
  assign w_ferr_fin = r_ferr | ~w_vote;
  assign w_par_exp  = (PARITY == 1) ? ~^r_data : ^r_data;
  assign w_perr     = (PARITY != 0) && (r_pbit != w_par_exp);
  assign w_break    = (r_data == '0) && ((PARITY == 0) || !r_pbit) && w_ferr_fin;
  assign w_done     = (r_state == S_STOP) && w_smp_end && (r_sidx == C_LAST_STP);
  assign w_push     = w_done && !w_break;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_bcnt  <= '0;
      r_idx   <= '0;
      r_sidx  <= 1'b0;
      r_data  <= '0;
      r_pbit  <= 1'b0;
      r_ferr  <= 1'b0;
      r_s0    <= 1'b1;
      r_s1    <= 1'b1;
    end else begin
      if (r_state != S_IDLE) r_bcnt <= w_bit_end ? '0 : r_bcnt + 1'b1;
      if (r_bcnt == C_SMP0) r_s0 <= r_rxs;
      if (r_bcnt == C_SMP1) r_s1 <= r_rxs;
      case (r_state)
        S_IDLE: begin
          if (r_armed && !r_rxs) begin
            r_state <= S_START;
            r_bcnt  <= '0;
            r_ferr  <= 1'b0;
          end
        end
        S_START: begin
          if (w_smp_end && w_vote) begin
            r_state <= S_IDLE;
          end else if (w_bit_end) begin
            r_state <= S_DATA;
            r_idx   <= '0;
          end
        end
        S_DATA: begin
          if (w_smp_end) r_data[r_idx] <= w_vote;
          if (w_bit_end) begin
            if (r_idx == C_LAST_IDX) begin
              r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
              r_sidx  <= 1'b0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (w_smp_end) r_pbit <= w_vote;
          if (w_bit_end) begin
            r_state <= S_STOP;
            r_sidx  <= 1'b0;
          end
        end
        S_STOP: begin
          // Completing mid-bit lets the FSM catch a start edge that follows immediately
          if (w_smp_end) begin
            r_ferr <= w_ferr_fin;
            if (r_sidx == C_LAST_STP) r_state <= w_break ? S_BRKWAIT : S_IDLE;
          end else if (w_bit_end) begin
            r_sidx <= r_sidx + 1'b1;
          end
        end
        S_BRKWAIT: begin
          if (r_rxs) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_dat   ({w_perr, w_ferr_fin, r_data}),
    .i_pop   (out_ready),
    .o_dat   (w_head),
    .o_vld   (out_valid),
    .o_full  (w_full),
    .o_count (count)
  );

  assign out_data = w_head[DATA_BITS-1:0];
  assign out_ferr = w_head[DATA_BITS];
  assign out_perr = w_head[DATA_BITS+1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_overflow <= 1'b0;
      r_brk      <= 1'b0;
    end else begin
      r_overflow <= w_push && w_full && !(out_valid && out_ready);
      r_brk      <= w_done && w_break;
    end
  end

  assign overflow = r_overflow;
  assign brk      = r_brk;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: dut_a is 8N1, dut_b is 8E1, both 16 clks/bit with a 4-entry FIFO.
module tb_uart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic rdy_a = 1'b0, rdy_b = 1'b0;
  logic [7:0] dat_a, dat_b;
  logic perr_a, ferr_a, vld_a, ovf_a, brk_a;
  logic perr_b, ferr_b, vld_b, ovf_b, brk_b;
  logic [2:0] cnt_a, cnt_b;

  int n_chk = 0;
  int n_fail = 0;
  int ovf_cnt_a = 0, brk_cnt_a = 0, ovf_cnt_b = 0, brk_cnt_b = 0;
  logic [9:0] sb_a[$];
  logic [9:0] sb_b[$];
  logic [9:0] e_a, e_b;
  int o0, b0;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_dut_a (
    .clk(clk), .reset(reset), .rx(rx_a), .out_data(dat_a), .out_perr(perr_a), .out_ferr(ferr_a),
    .out_valid(vld_a), .out_ready(rdy_a), .count(cnt_a), .overflow(ovf_a), .brk(brk_a));

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_dut_b (
    .clk(clk), .reset(reset), .rx(rx_b), .out_data(dat_b), .out_perr(perr_b), .out_ferr(ferr_b),
    .out_valid(vld_b), .out_ready(rdy_b), .count(cnt_b), .overflow(ovf_b), .brk(brk_b));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (ovf_a === 1'b1) ovf_cnt_a++;
    if (brk_a === 1'b1) brk_cnt_a++;
    if (ovf_b === 1'b1) ovf_cnt_b++;
    if (brk_b === 1'b1) brk_cnt_b++;
    if (vld_a === 1'b1 && rdy_a) begin
      if (sb_a.size() == 0) check("a_spurious_word", {31'd0, vld_a}, 32'd0);
      else begin
        e_a = sb_a.pop_front();
        check("a_data", {24'd0, dat_a}, {24'd0, e_a[7:0]});
        check("a_ferr", {31'd0, ferr_a}, {31'd0, e_a[8]});
        check("a_perr", {31'd0, perr_a}, {31'd0, e_a[9]});
      end
    end
    if (vld_b === 1'b1 && rdy_b) begin
      if (sb_b.size() == 0) check("b_spurious_word", {31'd0, vld_b}, 32'd0);
      else begin
        e_b = sb_b.pop_front();
        check("b_data", {24'd0, dat_b}, {24'd0, e_b[7:0]});
        check("b_ferr", {31'd0, ferr_b}, {31'd0, e_b[8]});
        check("b_perr", {31'd0, perr_b}, {31'd0, e_b[9]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_rx(input int d, input logic v);
    if (d == 0) rx_a = v;
    else rx_b = v;
  endtask

  task automatic hold(input int d, input logic v, input int n);
    set_rx(d, v);
    repeat (n) tick();
  endtask

  task automatic expect_frame(input int d, input logic [7:0] w, input logic pb, input logic stop);
    logic ferr, perr;
    ferr = !stop;
    perr = (d == 1) ? (pb != ^w) : 1'b0;
    if (d == 0) sb_a.push_back({perr, ferr, w});
    else sb_b.push_back({perr, ferr, w});
  endtask

  task automatic send_head(input int d, input logic [7:0] w, input logic pb);
    hold(d, 1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d, w[i], CPB);
    if (d == 1) hold(d, pb, CPB);
  endtask

  task automatic send_frame(input int d, input logic [7:0] w, input logic pb, input logic stop, input bit exp);
    if (exp) expect_frame(d, w, pb, stop);
    send_head(d, w, pb);
    hold(d, stop, CPB);
    set_rx(d, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    repeat (3) tick();
    @(negedge clk);
    check("rst_count", {29'd0, cnt_a}, 32'd0);
    check("rst_valid", {31'd0, vld_a}, 32'd0);
    check("rst_ovf", {31'd0, ovf_a}, 32'd0);
    check("rst_brk", {31'd0, brk_a}, 32'd0);
    check("rst_count_b", {29'd0, cnt_b}, 32'd0);
    tick();
    reset = 1'b1;
    repeat (10) tick();

    // back-to-back 8N1 frames
    rdy_a = 1'b1;
    send_frame(0, 8'h41, 1'b0, 1'b1, 1'b1);
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1);
    repeat (20) tick();
    check("t1_drained", sb_a.size(), 32'd0);
    check("t1_ovf", ovf_cnt_a, 32'd0);

    // even parity
    rdy_b = 1'b1;
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    repeat (20) tick();
    check("t2_drained", sb_b.size(), 32'd0);

    // overflow when full
    rdy_a = 1'b0;
    o0 = ovf_cnt_a;
    for (int i = 0; i < 5; i++) send_frame(0, 8'h11 + 8'(i), 1'b0, 1'b1, i < 4);
    repeat (20) tick();
    check("t3_count_full", {29'd0, cnt_a}, 32'd4);
    check("t3_ovf_pulses", ovf_cnt_a - o0, 32'd1);
    rdy_a = 1'b1;
    repeat (10) tick();
    check("t3_drained", sb_a.size(), 32'd0);
    check("t3_count_empty", {29'd0, cnt_a}, 32'd0);
    rdy_a = 1'b0;

    // full with a pop on the completion clk
    o0 = ovf_cnt_a;
    for (int i = 0; i < 4; i++) send_frame(0, 8'h21 + 8'(i), 1'b0, 1'b1, 1'b1);
    expect_frame(0, 8'h25, 1'b0, 1'b1);
    send_head(0, 8'h25, 1'b0);
    hold(0, 1'b1, 12);
    rdy_a = 1'b1;
    tick();
    rdy_a = 1'b0;
    hold(0, 1'b1, 3);
    repeat (10) tick();
    check("t3b_count", {29'd0, cnt_a}, 32'd4);
    check("t3b_ovf", ovf_cnt_a - o0, 32'd0);
    check("t3b_queued", sb_a.size(), 32'd4);
    rdy_a = 1'b1;
    repeat (10) tick();
    check("t3b_drained", sb_a.size(), 32'd0);

    // false start, then break, then a clean frame
    b0 = brk_cnt_a;
    hold(0, 1'b0, 4);
    hold(0, 1'b1, 40);
    check("t4_false_start_count", {29'd0, cnt_a}, 32'd0);
    hold(0, 1'b0, 2 * 10 * CPB);
    hold(0, 1'b1, 40);
    check("t4_brk_pulses", brk_cnt_a - b0, 32'd1);
    check("t4_brk_count", {29'd0, cnt_a}, 32'd0);
    send_frame(0, 8'h55, 1'b0, 1'b1, 1'b1);
    repeat (20) tick();
    check("t4_after_brk", sb_a.size(), 32'd0);

    // glitch on data bit 3 at mid-bit, then a framing error
    expect_frame(0, 8'h5A, 1'b0, 1'b1);
    hold(0, 1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        hold(0, 1'b1, 9);
        hold(0, 1'b0, 1);
        hold(0, 1'b1, 6);
      end else begin
        hold(0, (8'h5A >> i) & 8'h01 ? 1'b1 : 1'b0, CPB);
      end
    end
    hold(0, 1'b1, CPB);
    b0 = brk_cnt_a;
    send_frame(0, 8'h10, 1'b0, 1'b0, 1'b1);
    hold(0, 1'b1, 40);
    check("t5_ferr_no_brk", brk_cnt_a - b0, 32'd0);
    check("t5_drained", sb_a.size(), 32'd0);

    // reset mid-DATA with two words queued, rx held low through release
    rdy_a = 1'b0;
    send_frame(0, 8'h61, 1'b0, 1'b1, 1'b0);
    send_frame(0, 8'h62, 1'b0, 1'b1, 1'b0);
    repeat (20) tick();
    check("t6_pre_count", {29'd0, cnt_a}, 32'd2);
    hold(0, 1'b0, CPB);
    hold(0, 1'b1, CPB);
    hold(0, 1'b0, CPB / 2);
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("t6_rst_count", {29'd0, cnt_a}, 32'd0);
    check("t6_rst_valid", {31'd0, vld_a}, 32'd0);
    tick();
    reset = 1'b1;
    b0 = brk_cnt_a;
    hold(0, 1'b0, 12 * CPB);
    check("t6_low_no_brk", brk_cnt_a - b0, 32'd0);
    check("t6_low_count", {29'd0, cnt_a}, 32'd0);
    hold(0, 1'b1, 20);
    rdy_a = 1'b1;
    send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1);
    repeat (20) tick();
    check("t6_after_rst", sb_a.size(), 32'd0);
    check("b_ovf_total", ovf_cnt_b, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
